// File: rtl/posit_field_sorter.sv
// posit_field_sorter: two-stage, valid/ready pipelined ordering of two decoded posit operands.
// Define POSIT_SORTER_NAR_EN to add the a_nar/b_nar/out_nar ports and NaR ranking.
module posit_field_sorter #(
   parameter int W_REG = 4,
   parameter int W_EXP = 2,
   parameter int W_MAN = 16,
   parameter int W_TAG = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [W_TAG-1:0] in_tag,
   input  logic             a_sign,
   input  logic [W_REG-1:0] a_regime,
   input  logic [W_EXP-1:0] a_exponent,
   input  logic [W_MAN-1:0] a_mantissa,
   input  logic             b_sign,
   input  logic [W_REG-1:0] b_regime,
   input  logic [W_EXP-1:0] b_exponent,
   input  logic [W_MAN-1:0] b_mantissa,
`ifdef POSIT_SORTER_NAR_EN
   input  logic             a_nar,
   input  logic             b_nar,
   output logic             out_nar,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_TAG-1:0] out_tag,
   output logic             big_sign,
   output logic [W_REG-1:0] big_regime,
   output logic [W_EXP-1:0] big_exponent,
   output logic [W_MAN-1:0] big_mantissa,
   output logic             small_sign,
   output logic [W_REG-1:0] small_regime,
   output logic [W_EXP-1:0] small_exponent,
   output logic [W_MAN-1:0] small_mantissa,
   output logic             out_swap,
   output logic             out_equal
);
   localparam int W_OP = 1 + W_REG + W_EXP + W_MAN;

   logic             s1_valid_q, s1_valid_d, s1_signed_q;
   logic [W_TAG-1:0] s1_tag_q;
   logic [W_OP-1:0]  s1_a_q, s1_b_q;
   logic [5:0]       s1_cmp_q, cmp_s;
   logic             s2_valid_q, s2_valid_d, swap_q, swap_d, equal_q, equal_d;
   logic [W_TAG-1:0] tag_q, tag_d;
   logic [W_OP-1:0]  big_q, big_d, small_q, small_d;
   logic             s1_load_s, s2_load_s, in_ready_s;
   logic             mag_gt_s, mag_eq_s, ord_gt_s, ord_eq_s, fin_gt_s, fin_eq_s;
   logic             a_neg_s, b_neg_s;
`ifdef POSIT_SORTER_NAR_EN
   logic             s1_a_nar_q, s1_b_nar_q, nar_q, nar_d;
`endif

   // Handshake: S2 drains or refills whenever the consumer is not stalling it.
   assign s2_load_s  = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready_s = ~s1_valid_q | s2_load_s;
   assign s1_load_s  = in_valid & in_ready_s;
   assign in_ready   = in_ready_s;

   // Field compares, packed as {reg_gt, reg_eq, exp_gt, exp_eq, man_gt, man_eq}.
   assign cmp_s = {($signed(a_regime) > $signed(b_regime)),     (a_regime == b_regime),
                   ($signed(a_exponent) > $signed(b_exponent)), (a_exponent == b_exponent),
                   (a_mantissa > b_mantissa),                   (a_mantissa == b_mantissa)};

   // S1 valid next-state.
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (s1_load_s) begin
         s1_valid_d = 1'b1;
      end else if (s2_load_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // S1 register stage: operands, mode, tag and compare flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_signed_q <= 1'b0;
         s1_tag_q    <= {W_TAG{1'b0}};
         s1_a_q      <= {W_OP{1'b0}};
         s1_b_q      <= {W_OP{1'b0}};
         s1_cmp_q    <= 6'b000000;
`ifdef POSIT_SORTER_NAR_EN
         s1_a_nar_q  <= 1'b0;
         s1_b_nar_q  <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_load_s) begin
            s1_signed_q <= in_signed;
            s1_tag_q    <= in_tag;
            s1_a_q      <= {a_sign, a_regime, a_exponent, a_mantissa};
            s1_b_q      <= {b_sign, b_regime, b_exponent, b_mantissa};
            s1_cmp_q    <= cmp_s;
`ifdef POSIT_SORTER_NAR_EN
            s1_a_nar_q  <= a_nar;
            s1_b_nar_q  <= b_nar;
`endif
         end
      end
   end

   // Ordering decision; a tie never swaps, so big = B whenever the operands are equal.
   always_comb begin
      a_neg_s  = s1_a_q[W_OP-1];
      b_neg_s  = s1_b_q[W_OP-1];
      mag_gt_s = s1_cmp_q[5] | (s1_cmp_q[4] & s1_cmp_q[3]) | (s1_cmp_q[4] & s1_cmp_q[2] & s1_cmp_q[1]);
      mag_eq_s = s1_cmp_q[4] & s1_cmp_q[2] & s1_cmp_q[0];
      ord_gt_s = mag_gt_s;
      ord_eq_s = mag_eq_s;
      if (s1_signed_q && (a_neg_s != b_neg_s)) begin
         ord_gt_s = ~a_neg_s;
         ord_eq_s = 1'b0;
      end else if (s1_signed_q && a_neg_s) begin
         ord_gt_s = ~mag_gt_s & ~mag_eq_s;
         ord_eq_s = mag_eq_s;
      end else begin
         ord_gt_s = mag_gt_s;
         ord_eq_s = mag_eq_s;
      end
      fin_gt_s = ord_gt_s;
      fin_eq_s = ord_eq_s;
`ifdef POSIT_SORTER_NAR_EN
      if (s1_a_nar_q && s1_b_nar_q) begin
         fin_gt_s = 1'b0;
         fin_eq_s = 1'b1;
      end else if (s1_a_nar_q) begin
         fin_gt_s = 1'b0;
         fin_eq_s = 1'b0;
      end else if (s1_b_nar_q) begin
         fin_gt_s = 1'b1;
         fin_eq_s = 1'b0;
      end else begin
         fin_gt_s = ord_gt_s;
         fin_eq_s = ord_eq_s;
      end
`endif
   end

   // S2 next-state: load an ordered result, empty on a pop, otherwise hold.
   always_comb begin
      s2_valid_d = s2_valid_q;
      big_d      = big_q;
      small_d    = small_q;
      tag_d      = tag_q;
      swap_d     = swap_q;
      equal_d    = equal_q;
`ifdef POSIT_SORTER_NAR_EN
      nar_d      = nar_q;
`endif
      if (s2_load_s) begin
         s2_valid_d = 1'b1;
         big_d      = fin_gt_s ? s1_a_q : s1_b_q;
         small_d    = fin_gt_s ? s1_b_q : s1_a_q;
         tag_d      = s1_tag_q;
         swap_d     = fin_gt_s;
         equal_d    = fin_eq_s;
`ifdef POSIT_SORTER_NAR_EN
         nar_d      = s1_a_nar_q | s1_b_nar_q;
`endif
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // S2 register stage; every output is driven from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         big_q      <= {W_OP{1'b0}};
         small_q    <= {W_OP{1'b0}};
         tag_q      <= {W_TAG{1'b0}};
         swap_q     <= 1'b0;
         equal_q    <= 1'b0;
`ifdef POSIT_SORTER_NAR_EN
         nar_q      <= 1'b0;
`endif
      end else begin
         s2_valid_q <= s2_valid_d;
         big_q      <= big_d;
         small_q    <= small_d;
         tag_q      <= tag_d;
         swap_q     <= swap_d;
         equal_q    <= equal_d;
`ifdef POSIT_SORTER_NAR_EN
         nar_q      <= nar_d;
`endif
      end
   end

   assign out_valid = s2_valid_q;
   assign out_tag   = tag_q;
   assign out_swap  = swap_q;
   assign out_equal = equal_q;
   assign {big_sign, big_regime, big_exponent, big_mantissa}         = big_q;
   assign {small_sign, small_regime, small_exponent, small_mantissa} = small_q;
`ifdef POSIT_SORTER_NAR_EN
   assign out_nar = nar_q;
`endif
endmodule

// File: tb/tb_posit_field_sorter.sv
// Directed self-checking bench for posit_field_sorter: ordering rules, latency, backpressure, reset.
module tb_posit_field_sorter;
   localparam int W_REG = 4;
   localparam int W_EXP = 2;
   localparam int W_MAN = 16;
   localparam int W_TAG = 4;
   localparam int W_OP  = 1 + W_REG + W_EXP + W_MAN;

   logic             clk = 1'b0;
   logic             rst, in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [W_TAG-1:0] in_tag, out_tag;
   logic             a_sign, b_sign, big_sign, small_sign, out_swap, out_equal;
   logic [W_REG-1:0] a_regime, b_regime, big_regime, small_regime;
   logic [W_EXP-1:0] a_exponent, b_exponent, big_exponent, small_exponent;
   logic [W_MAN-1:0] a_mantissa, b_mantissa, big_mantissa, small_mantissa;
`ifdef POSIT_SORTER_NAR_EN
   logic             a_nar, b_nar, out_nar;
`endif

   int               n_cmp = 0;
   int               n_err = 0;
   logic [W_OP-1:0]  exp_a, exp_b;
   logic [W_TAG-1:0] exp_tag;
   logic             exp_nar;

   posit_field_sorter #(.W_REG(W_REG), .W_EXP(W_EXP), .W_MAN(W_MAN), .W_TAG(W_TAG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
      .in_tag(in_tag),
      .a_sign(a_sign), .a_regime(a_regime), .a_exponent(a_exponent), .a_mantissa(a_mantissa),
      .b_sign(b_sign), .b_regime(b_regime), .b_exponent(b_exponent), .b_mantissa(b_mantissa),
`ifdef POSIT_SORTER_NAR_EN
      .a_nar(a_nar), .b_nar(b_nar), .out_nar(out_nar),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .big_sign(big_sign), .big_regime(big_regime), .big_exponent(big_exponent),
      .big_mantissa(big_mantissa),
      .small_sign(small_sign), .small_regime(small_regime), .small_exponent(small_exponent),
      .small_mantissa(small_mantissa),
      .out_swap(out_swap), .out_equal(out_equal)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string nm, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", nm, obs, expv);
      end
   endtask

   function automatic logic [W_OP-1:0] op(input logic s, input logic [W_REG-1:0] r,
                                          input logic [W_EXP-1:0] e, input logic [W_MAN-1:0] m);
      return {s, r, e, m};
   endfunction

   function automatic logic [W_OP-1:0] big_obs();
      return {big_sign, big_regime, big_exponent, big_mantissa};
   endfunction

   function automatic logic [W_OP-1:0] small_obs();
      return {small_sign, small_regime, small_exponent, small_mantissa};
   endfunction

   task automatic drive_item(input logic sgn, input logic [W_TAG-1:0] tg,
                             input logic [W_OP-1:0] a, input logic [W_OP-1:0] b);
      in_valid  = 1'b1;
      in_signed = sgn;
      in_tag    = tg;
      {a_sign, a_regime, a_exponent, a_mantissa} = a;
      {b_sign, b_regime, b_exponent, b_mantissa} = b;
      exp_a   = a;
      exp_b   = b;
      exp_tag = tg;
`ifdef POSIT_SORTER_NAR_EN
      exp_nar = a_nar | b_nar;
`else
      exp_nar = 1'b0;
`endif
   endtask

   // Called at a negedge right after drive_item on an empty pipeline.
   task automatic expect_result(input string nm, input logic e_swap, input logic e_eq);
      out_ready = 1'b1;
      #1 check_val({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check_val({nm, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check_val({nm, "_valid"}, 32'(out_valid), 32'd1);
      check_val({nm, "_tag"},   32'(out_tag),   32'(exp_tag));
      check_val({nm, "_swap"},  32'(out_swap),  32'(e_swap));
      check_val({nm, "_equal"}, 32'(out_equal), 32'(e_eq));
      check_val({nm, "_big"},   32'(big_obs()),   32'(e_swap ? exp_a : exp_b));
      check_val({nm, "_small"}, 32'(small_obs()), 32'(e_swap ? exp_b : exp_a));
`ifdef POSIT_SORTER_NAR_EN
      check_val({nm, "_nar"},   32'(out_nar),   32'(exp_nar));
`endif
      @(negedge clk);
      check_val({nm, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int next_in, n_out, inflight;
      logic pop, push, prev_stall;
      logic [W_TAG-1:0] prev_tag;
      logic [W_OP-1:0]  prev_big;

      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_tag = 4'd0; out_ready = 1'b0;
      {a_sign, a_regime, a_exponent, a_mantissa} = {W_OP{1'b0}};
      {b_sign, b_regime, b_exponent, b_mantissa} = {W_OP{1'b0}};
`ifdef POSIT_SORTER_NAR_EN
      a_nar = 1'b0; b_nar = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_in_ready",  32'(in_ready),  32'd1);
      check_val("rst_tag",       32'(out_tag),   32'd0);
      check_val("rst_flags",     32'({out_swap, out_equal}), 32'd0);
      check_val("rst_big",       32'(big_obs()),   32'd0);
      check_val("rst_small",     32'(small_obs()), 32'd0);
      rst = 1'b0;

      drive_item(1'b0, 4'd1, op(1'b0, 4'd2, 2'd0, 16'h0000), op(1'b0, 4'd1, 2'd0, 16'h0000));
      expect_result("mag_reg", 1'b1, 1'b0);
      drive_item(1'b1, 4'd2, op(1'b1, 4'd3, 2'd0, 16'h0000), op(1'b1, 4'd1, 2'd0, 16'h0000));
      expect_result("sgn_negneg", 1'b0, 1'b0);
      drive_item(1'b0, 4'd3, op(1'b1, 4'd0, 2'd1, 16'h8000), op(1'b0, 4'd0, 2'd1, 16'h8000));
      expect_result("mag_tie", 1'b0, 1'b1);
      drive_item(1'b1, 4'd4, op(1'b0, 4'd0, 2'd1, 16'h8000), op(1'b0, 4'd0, 2'd1, 16'h8000));
      expect_result("sgn_tie_pos", 1'b0, 1'b1);
      drive_item(1'b1, 4'd5, op(1'b1, 4'd0, 2'd1, 16'h8000), op(1'b1, 4'd0, 2'd1, 16'h8000));
      expect_result("sgn_tie_neg", 1'b0, 1'b1);
      drive_item(1'b1, 4'd6, op(1'b0, 4'hD, 2'd0, 16'h0000), op(1'b1, 4'd5, 2'd0, 16'h0000));
      expect_result("sgn_apos", 1'b1, 1'b0);
      drive_item(1'b0, 4'd7, op(1'b0, 4'hF, 2'd3, 16'hFFFF), op(1'b0, 4'd1, 2'd0, 16'h0000));
      expect_result("mag_negreg", 1'b0, 1'b0);
      drive_item(1'b0, 4'd8, op(1'b0, 4'd0, 2'b10, 16'hFFFF), op(1'b0, 4'd0, 2'd1, 16'h0000));
      expect_result("mag_exp", 1'b0, 1'b0);
      drive_item(1'b0, 4'd9, op(1'b0, 4'd1, 2'd1, 16'h1234), op(1'b0, 4'd1, 2'd1, 16'h1233));
      expect_result("mag_man", 1'b1, 1'b0);
      drive_item(1'b1, 4'd10, op(1'b1, 4'd1, 2'd1, 16'h0001), op(1'b1, 4'd1, 2'd1, 16'h0002));
      expect_result("sgn_negman", 1'b1, 1'b0);
      drive_item(1'b1, 4'd11, op(1'b0, 4'd2, 2'd0, 16'h0005), op(1'b0, 4'd2, 2'd1, 16'h0005));
      expect_result("sgn_pospos", 1'b0, 1'b0);
      drive_item(1'b1, 4'd12, op(1'b1, 4'd7, 2'd1, 16'hFFFF), op(1'b0, 4'h8, 2'd2, 16'h0000));
      expect_result("sgn_bpos", 1'b0, 1'b0);
`ifdef POSIT_SORTER_NAR_EN
      a_nar = 1'b1;
      drive_item(1'b1, 4'd13, op(1'b0, 4'd2, 2'd0, 16'h0000), op(1'b1, 4'd1, 2'd0, 16'h0000));
      expect_result("nar_a", 1'b0, 1'b0);
      b_nar = 1'b1;
      drive_item(1'b0, 4'd14, op(1'b0, 4'd2, 2'd0, 16'h0000), op(1'b0, 4'd1, 2'd0, 16'h0000));
      expect_result("nar_both", 1'b0, 1'b1);
      a_nar = 1'b0;
      drive_item(1'b0, 4'd15, op(1'b0, 4'd2, 2'd0, 16'h0000), op(1'b0, 4'd1, 2'd0, 16'h0000));
      expect_result("nar_b", 1'b1, 1'b0);
      b_nar = 1'b0;
`endif

      // Stream of 8 items, consumer stalls on slots 3-5.
      next_in = 0; n_out = 0; inflight = 0; prev_stall = 1'b0;
      prev_tag = 4'd0; prev_big = {W_OP{1'b0}};
      for (int slot = 0; slot < 40 && n_out < 8; slot++) begin
         @(negedge clk);
         if (prev_stall) begin
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_tag",   32'(out_tag),   32'(prev_tag));
            check_val("stall_big",   32'(big_obs()), 32'(prev_big));
         end
         out_ready = !(slot >= 3 && slot <= 5);
         if (next_in < 8) begin
            drive_item(1'b0, 4'(next_in), op(1'b0, 4'(next_in), 2'd0, 16'h0000),
                       op(1'b0, 4'd3, 2'd0, 16'h0000));
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check_val("stream_in_ready", 32'(in_ready), 32'((inflight == 2 && !out_ready) ? 0 : 1));
         pop  = out_valid & out_ready;
         push = in_valid & in_ready;
         if (pop) begin
            check_val("stream_tag",   32'(out_tag),   32'(n_out));
            check_val("stream_swap",  32'(out_swap),  32'(n_out > 3));
            check_val("stream_equal", 32'(out_equal), 32'(n_out == 3));
            n_out++;
         end
         prev_stall = out_valid & ~out_ready;
         prev_tag   = out_tag;
         prev_big   = big_obs();
         if (push) next_in++;
         inflight = inflight + int'(push) - int'(pop);
      end
      in_valid = 1'b0;
      check_val("stream_out_count", 32'(n_out), 32'd8);
      check_val("stream_in_count",  32'(next_in), 32'd8);
      @(negedge clk);
      check_val("stream_no_dup", 32'(out_valid), 32'd0);

      // Reset with two items in flight.
      out_ready = 1'b0;
      drive_item(1'b0, 4'd10, op(1'b0, 4'd1, 2'd0, 16'h0000), op(1'b0, 4'd2, 2'd0, 16'h0000));
      @(negedge clk);
      drive_item(1'b0, 4'd11, op(1'b0, 4'd1, 2'd0, 16'h0000), op(1'b0, 4'd2, 2'd0, 16'h0000));
      @(negedge clk);
      in_valid = 1'b0;
      check_val("flight_valid", 32'(out_valid), 32'd1);
      check_val("flight_tag",   32'(out_tag),   32'd10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_valid",    32'(out_valid), 32'd0);
      check_val("midrst_in_ready", 32'(in_ready),  32'd1);
      check_val("midrst_tag",      32'(out_tag),   32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("midrst_no_stale", 32'(out_valid), 32'd0);
      end
      drive_item(1'b0, 4'd12, op(1'b0, 4'd3, 2'd0, 16'h0000), op(1'b0, 4'd2, 2'd0, 16'h0000));
      expect_result("post_rst", 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
